// File: rtl/axi_downsizer_if.sv
// Valid/ready bus for axi_downsizer: wide words in, narrow beats out.
interface axi_downsizer_if #(
   parameter int IN_WIDTH  = 64,
   parameter int OUT_WIDTH = 16
);
   logic                 vld_in;
   logic                 rdy_in;
   logic [IN_WIDTH-1:0]  data_in;
   logic                 vld_out;
   logic                 rdy_out;
   logic [OUT_WIDTH-1:0] data_out;
   logic                 last_out;

   modport slave (
      input  vld_in, data_in, rdy_out,
      output rdy_in, vld_out, data_out, last_out
   );

   modport master (
      output vld_in, data_in, rdy_out,
      input  rdy_in, vld_out, data_out, last_out
   );
endinterface

// File: rtl/axi_downsizer.sv
// Splits each IN_WIDTH word into IN_WIDTH/OUT_WIDTH beats, LSB slice first.
// Define AXI_DOWNSIZER_BYPASS_EN to accept the next word on the last beat.
module axi_downsizer #(
   parameter int IN_WIDTH  = 64,
   parameter int OUT_WIDTH = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   axi_downsizer_if.slave  bus
);
   localparam int RATIO      = IN_WIDTH / OUT_WIDTH;
   localparam int BEAT_WIDTH = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam logic [BEAT_WIDTH-1:0] LAST_BEAT = BEAT_WIDTH'(RATIO - 1);

   typedef enum logic {EMPTY, SEND} state_t;

   state_t                state;
   logic [BEAT_WIDTH-1:0] beat;
   logic [IN_WIDTH-1:0]   hold;
   logic                  is_last;
   logic                  accept;

   assign is_last = (beat == LAST_BEAT);

   assign bus.vld_out  = (state == SEND);
   assign bus.last_out = (state == SEND) && is_last;
   assign bus.data_out = hold[int'(beat)*OUT_WIDTH +: OUT_WIDTH];

`ifdef AXI_DOWNSIZER_BYPASS_EN
   // Refill on the final handshake so words stream without a bubble.
   assign bus.rdy_in = rst_n &&
      ((state == EMPTY) || (is_last && bus.rdy_out));
`else
   assign bus.rdy_in = rst_n && (state == EMPTY);
`endif

   assign accept = bus.vld_in && bus.rdy_in;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= EMPTY;
         beat  <= '0;
         hold  <= '0;
      end else begin
         unique case (state)
            EMPTY: begin
               if (accept) begin
                  hold  <= bus.data_in;
                  beat  <= '0;
                  state <= SEND;
               end
            end
            SEND: begin
               if (bus.rdy_out) begin
                  if (!is_last) begin
                     beat <= beat + BEAT_WIDTH'(1);
                  end else if (accept) begin
                     hold <= bus.data_in;
                     beat <= '0;
                  end else begin
                     beat  <= '0;
                     state <= EMPTY;
                  end
               end
            end
         endcase
      end
   end
endmodule
